alu_issue: RTL
==============

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: ILL_CNT_W, default 8, width of the saturating illegal-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream instruction word valid.
REQ-005 in_ready  output  1  block can accept an instruction this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 pc  input  32  address of instr.
REQ-008 rs1_data  input  32  register-file value for instr[19:15], valid with in_valid.
REQ-009 rs2_data  input  32  register-file value for instr[24:20], valid with in_valid.
REQ-010 out_valid  output  1  head entry valid toward ALU stage.
REQ-011 out_ready  input  1  ALU stage accepts head entry.
REQ-012 alu_op  output  4  ALU operation, ALUInstr package enumeration (ADD, SUB, SLL, SRL, SRA, OR, AND, XOR, SLT, ULT, UGTE, EQ, SGTE).
REQ-013 alu_in1  output  32  first ALU operand.
REQ-014 alu_in2  output  32  second ALU operand.
REQ-015 rd  output  5  destination register.
REQ-016 rd_we  output  1  result written back.
REQ-017 is_branch  output  1  entry is a conditional branch compare.
REQ-018 br_inv  output  1  branch taken when ALU result is 0 (BNE).
REQ-019 illegal  output  1  entry decoded as unsupported.
REQ-020 ill_cnt  output  ILL_CNT_W  count of accepted illegal instructions.

Function
REQ-021 Decode is combinational on accepted input; result is stored in a 2-entry FIFO; outputs drive from FIFO head only.
REQ-022 Handshake: transfer in when in_valid && in_ready; out when out_valid && out_ready; in_ready = (count < 2); out_valid = (count > 0).
REQ-023 Latency: instruction accepted at edge N appears at outputs after edge N, out_valid high the cycle following acceptance if FIFO was empty.
REQ-024 Simultaneous push and pop: count unchanged, order preserved; at count 2 push impossible (in_ready low), pop alone gives count 1.
REQ-025 Outputs hold stable while out_valid && !out_ready.
REQ-026 OP (0110011): funct7 0000000 -> ADD/SLL/SLT/ULT(SLTU)/XOR/SRL/OR/AND by funct3; funct7 0100000 with funct3 000 -> SUB, 101 -> SRA; other funct7/funct3 combos illegal; in1=rs1_data, in2=rs2_data.
REQ-027 OP-IMM (0010011): ADDI/SLTI/SLTIU(ULT)/XORI/ORI/ANDI use in2 = sign-extended instr[31:20]; SLLI needs funct7 0000000, SRLI 0000000, SRAI 0100000, else illegal; shift in2 = {27'b0, instr[24:20]}.
REQ-028 LUI (0110111): ADD, in1=0, in2={instr[31:12],12'b0}; AUIPC (0010111): ADD, in1=pc, same in2.
REQ-029 BRANCH (1100011): BEQ->EQ, BNE->EQ with br_inv=1, BLT->SLT, BGE->SGTE, BLTU->ULT, BGEU->UGTE; funct3 010/011 illegal; is_branch=1, rd=0, rd_we=0; operands rs1_data/rs2_data.
REQ-030 rd = instr[11:7] for non-branch; rd_we = 1 only when legal, non-branch and rd != 0.
REQ-031 Illegal entry: illegal=1, alu_op=ADD, in1=in2=0, rd_we=0, is_branch=0, br_inv=0; still enqueued and handshaked normally.
REQ-032 ill_cnt increments by 1 on each accepted illegal instruction, saturates at all-ones.
REQ-033 is_branch, br_inv = 0 for all non-branch entries.

Reset
REQ-034 rst_n low asynchronously clears FIFO (count 0, out_valid 0), ill_cnt 0, all payload outputs 0; in_ready reads 1 while rst_n low and after release.
REQ-035 Reset mid-operation discards all buffered entries; no entry reappears after release.

Verification
REQ-036 ADD x3,x1,x2 with rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_op=ADD, in1=5, in2=7, rd=3, rd_we=1.
REQ-037 ADDI x1,x0,-1 (0xFFF00093), SRAI x2,x1,4, LUI x5,0x12345 -> in2=0xFFFFFFFF; in2=4 with SRA; in1=0, in2=0x12345000.
REQ-038 BNE x1,x2 then BGEU -> EQ/br_inv=1/is_branch=1/rd_we=0; UGTE/br_inv=0.
REQ-039 out_ready=0, push three back-to-back -> in_ready low after 2 accepted; raise out_ready -> entries exit in order, one per cycle, no loss/duplication.
REQ-040 Stream 300 words 0x00000000 -> each illegal=1, rd_we=0; ill_cnt saturates at 255.
REQ-041 Assert rst_n low with 2 entries buffered -> out_valid=0, ill_cnt=0 immediately; after release first output is the next new instruction.

Source files
------------

// File: rtl/alu_issue.sv
// RV32I integer-ALU issue stage: decodes one instruction into ALU controls and
// operands, and buffers the results in a 2-entry FIFO that drives the ALU stage.
module alu_issue #(
   parameter int ILL_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          instr,
   input  logic [31:0]          pc,
   input  logic [31:0]          rs1_data,
   input  logic [31:0]          rs2_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [3:0]           alu_op,
   output logic [31:0]          alu_in1,
   output logic [31:0]          alu_in2,
   output logic [4:0]           rd,
   output logic                 rd_we,
   output logic                 is_branch,
   output logic                 br_inv,
   output logic                 illegal,
   output logic [ILL_CNT_W-1:0] ill_cnt
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SLL  = 4'd2,
      OP_SRL  = 4'd3,
      OP_SRA  = 4'd4,
      OP_OR   = 4'd5,
      OP_AND  = 4'd6,
      OP_XOR  = 4'd7,
      OP_SLT  = 4'd8,
      OP_ULT  = 4'd9,
      OP_UGTE = 4'd10,
      OP_EQ   = 4'd11,
      OP_SGTE = 4'd12
   } alu_op_e;

   typedef struct packed {
      alu_op_e     op;
      logic [31:0] in1;
      logic [31:0] in2;
      logic [4:0]  rd;
      logic        rd_we;
      logic        is_branch;
      logic        br_inv;
      logic        illegal;
   } entry_t;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic [31:0] shamt;
   logic        unused_rs1_field;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_u  = {instr[31:12], 12'b0};
   assign shamt  = {27'b0, instr[24:20]};
   assign unused_rs1_field = ^instr[19:15];

   logic        legal;
   logic        branch;
   logic        inv;
   alu_op_e     op;
   logic [31:0] in1;
   logic [31:0] in2;
   entry_t      dec;

   // Decode starts from "illegal, register operands" and each recognised
   // encoding marks itself legal; the squash to a harmless ADD 0,0 happens last.
   always_comb begin
      legal  = 1'b0;
      branch = 1'b0;
      inv    = 1'b0;
      op     = OP_ADD;
      in1    = rs1_data;
      in2    = rs2_data;
      case (opcode)
         7'b0110011: begin
            if (funct7 == 7'b0000000) begin
               legal = 1'b1;
               case (funct3)
                  3'b000: op = OP_ADD;
                  3'b001: op = OP_SLL;
                  3'b010: op = OP_SLT;
                  3'b011: op = OP_ULT;
                  3'b100: op = OP_XOR;
                  3'b101: op = OP_SRL;
                  3'b110: op = OP_OR;
                  3'b111: op = OP_AND;
               endcase
            end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
               legal = 1'b1;
               op    = (funct3 == 3'b000) ? OP_SUB : OP_SRA;
            end
         end
         7'b0010011: begin
            in2 = imm_i;
            case (funct3)
               3'b000: begin legal = 1'b1; op = OP_ADD; end
               3'b010: begin legal = 1'b1; op = OP_SLT; end
               3'b011: begin legal = 1'b1; op = OP_ULT; end
               3'b100: begin legal = 1'b1; op = OP_XOR; end
               3'b110: begin legal = 1'b1; op = OP_OR;  end
               3'b111: begin legal = 1'b1; op = OP_AND; end
               3'b001: begin
                  in2   = shamt;
                  op    = OP_SLL;
                  legal = (funct7 == 7'b0000000);
               end
               3'b101: begin
                  in2 = shamt;
                  if (funct7 == 7'b0000000) begin
                     legal = 1'b1;
                     op    = OP_SRL;
                  end else if (funct7 == 7'b0100000) begin
                     legal = 1'b1;
                     op    = OP_SRA;
                  end
               end
            endcase
         end
         7'b0110111: begin
            legal = 1'b1;
            in1   = 32'b0;
            in2   = imm_u;
         end
         7'b0010111: begin
            legal = 1'b1;
            in1   = pc;
            in2   = imm_u;
         end
         7'b1100011: begin
            branch = 1'b1;
            case (funct3)
               3'b000: begin legal = 1'b1; op = OP_EQ; end
               3'b001: begin legal = 1'b1; op = OP_EQ; inv = 1'b1; end
               3'b100: begin legal = 1'b1; op = OP_SLT;  end
               3'b101: begin legal = 1'b1; op = OP_SGTE; end
               3'b110: begin legal = 1'b1; op = OP_ULT;  end
               3'b111: begin legal = 1'b1; op = OP_UGTE; end
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase

      dec           = '0;
      dec.illegal   = !legal;
      dec.op        = legal ? op : OP_ADD;
      dec.in1       = legal ? in1 : 32'b0;
      dec.in2       = legal ? in2 : 32'b0;
      dec.is_branch = legal && branch;
      dec.br_inv    = legal && inv;
      dec.rd        = (legal && branch) ? 5'b0 : instr[11:7];
      dec.rd_we     = legal && !branch && (instr[11:7] != 5'b0);
   end

   entry_t     fifo [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic       push;
   logic       pop;
   entry_t     head;

   assign in_ready  = (count < 2'd2);
   assign out_valid = (count > 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign head      = fifo[rd_ptr];

   // Two-slot ring buffer; the head slot only changes on a pop, so outputs
   // hold steady while the ALU stage stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo[0] <= '0;
         fifo[1] <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= 2'd0;
         ill_cnt <= '0;
      end else begin
         if (push) begin
            fifo[wr_ptr] <= dec;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (push && dec.illegal && (ill_cnt != {ILL_CNT_W{1'b1}})) begin
            ill_cnt <= ill_cnt + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign alu_op    = head.op;
   assign alu_in1   = head.in1;
   assign alu_in2   = head.in2;
   assign rd        = head.rd;
   assign rd_we     = head.rd_we;
   assign is_branch = head.is_branch;
   assign br_inv    = head.br_inv;
   assign illegal   = head.illegal;

endmodule
